// File: rtl/text_layer.sv
// Text overlay producer: char buffer + per-pixel font_rom address/bit index + clear-screen sweep.
// Latency: one registered stage with DrawX+1 lookahead, so outputs line up with the current DrawX.
// Backpressure: none; writes are dropped while the clear sweep runs (busy=1). Optional blink: TEXT_BLINK_EN.
module text_layer #(
    parameter int TEXT_COLS = 80,
    parameter int TEXT_ROWS = 30,
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_clk,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clear_req,
    output logic        busy,
    output logic [10:0] font_addr,
    output logic [3:0]  text_offset,
    output logic        draw_text
);

    localparam int          CELLS   = TEXT_COLS * TEXT_ROWS;
    localparam logic [11:0] CELLS12 = 12'(CELLS);
    localparam logic [11:0] COLS12  = 12'(TEXT_COLS);
    localparam logic [10:0] X_LO    = 11'(ORIGIN_X);
    localparam logic [9:0]  Y_LO    = 10'(ORIGIN_Y);
    localparam logic [10:0] W_PX    = 11'(8 * TEXT_COLS);
    localparam logic [9:0]  H_PX    = 10'(16 * TEXT_ROWS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q;
    logic [11:0] clr_addr_q;
    logic        busy_q;

    logic [7:0]  mem [0:CELLS-1];
    logic [7:0]  char_q;
    logic [3:0]  glyph_q;
    logic [2:0]  xoff_q;
    logic        win_q;

    logic [10:0] px_d;
    logic [11:0] px_rel;
    logic [10:0] py_rel;
    logic [11:0] col;
    logic [11:0] row;
    logic        win_d;
    logic [11:0] raddr_d;
    logic [3:0]  glyph_d;
    logic [2:0]  xoff_d;

    logic        we_d;
    logic [11:0] waddr_d;
    logic [7:0]  wdata_d;

    // Lookahead pixel position, window test and char-cell address for the next pixel.
    // The relative offsets carry a borrow bit so "left of / above the origin" needs no signed compare.
    always_comb begin
        px_d    = {1'b0, DrawX} + 11'd1;
        px_rel  = {1'b0, px_d} - {1'b0, X_LO};
        py_rel  = {1'b0, DrawY} - {1'b0, Y_LO};
        col     = 12'(px_rel[10:3]);
        row     = 12'(py_rel[9:4]);
        win_d   = !px_rel[11] && (px_rel[10:0] < W_PX) &&
                  !py_rel[10] && (py_rel[9:0] < H_PX);
        raddr_d = win_d ? (row * COLS12 + col) : 12'd0;
        glyph_d = py_rel[3:0];
        xoff_d  = 3'd7 - px_rel[2:0];
    end

    // Single RAM write port: the sweep owns it in CLEAR, software owns it in IDLE.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = clr_addr_q;
        wdata_d = 8'h20;
        if (state_q == CLEAR) begin
            we_d = 1'b1;
        end else if (wr_en && (wr_addr < CELLS12)) begin
            we_d    = 1'b1;
            waddr_d = wr_addr;
            wdata_d = wr_data;
        end
    end

    // Character RAM write; contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (we_d) mem[waddr_d] <= wdata_d;
    end

    // Synchronous RAM read (old data on same-cell write) plus the rest of the pixel stage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            char_q  <= 8'd0;
            glyph_q <= 4'd0;
            xoff_q  <= 3'd0;
            win_q   <= 1'b0;
        end else begin
            char_q  <= mem[raddr_d];
            glyph_q <= glyph_d;
            xoff_q  <= xoff_d;
            win_q   <= win_d;
        end
    end

    // Clear-sweep FSM: one cell per cycle, busy registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            clr_addr_q <= 12'd0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= 12'd0;
                        busy_q     <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + 12'd1;
                    if (clr_addr_q == CELLS12 - 12'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign font_addr   = {char_q[6:0], glyph_q};
    assign text_offset = {1'b0, xoff_q};

`ifdef TEXT_BLINK_EN
    logic       fc_sync_q;
    logic       fc_prev_q;
    logic [4:0] frame_cnt_q;

    // Rising-edge detect on vsync into a free-running 32-frame blink counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_sync_q   <= 1'b0;
            fc_prev_q   <= 1'b0;
            frame_cnt_q <= 5'd0;
        end else begin
            fc_sync_q <= frame_clk;
            fc_prev_q <= fc_sync_q;
            if (fc_sync_q && !fc_prev_q) frame_cnt_q <= frame_cnt_q + 5'd1;
        end
    end

    assign draw_text = win_q && !(frame_cnt_q[4] && char_q[7]);
`else
    // Attribute bit and vsync are accepted but have no effect in this build.
    logic unused_blink;
    assign unused_blink = frame_clk ^ char_q[7];
    assign draw_text    = win_q;
`endif

endmodule

// File: tb/tb_text_layer.sv
module tb_text_layer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frame_clk;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clear_req;
    logic        busy;
    logic [10:0] font_addr;
    logic [3:0]  text_offset;
    logic        draw_text;

    int checks = 0;
    int errors = 0;
    int cnt;

    text_layer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .frame_clk  (frame_clk),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .busy       (busy),
        .font_addr  (font_addr),
        .text_offset(text_offset),
        .draw_text  (draw_text)
    );

    always #5 Clk = ~Clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_cell(input logic [11:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        DrawX = x; DrawY = y;
        tick();
    endtask

    initial begin
        Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; frame_clk = 1'b0;
        wr_en = 1'b0; wr_addr = 12'd0; wr_data = 8'd0; clear_req = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_font_addr", 32'(font_addr), 32'd0);
        chk("rst_text_offset", 32'(text_offset), 32'd0);
        chk("rst_draw_text", 32'(draw_text), 32'd0);
        Reset = 1'b0;
        tick();

        // Cell 0 = 'A', pixel (1,3): glyph row 3, bit 6.
        write_cell(12'd0, 8'h41);
        pixel(10'd0, 10'd3);
        chk("a_font_addr", 32'(font_addr), 32'h413);
        chk("a_offset", 32'(text_offset), 32'd6);
        chk("a_draw", 32'(draw_text), 32'd1);

        // Cell 81 (row1,col1) = 'Z', pixel (9,17).
        write_cell(12'd81, 8'h5A);
        pixel(10'd8, 10'd17);
        chk("z_font_addr", 32'(font_addr), 32'h5A1);
        chk("z_offset", 32'(text_offset), 32'd6);
        chk("z_draw", 32'(draw_text), 32'd1);

        // Window edges: last in-window pixel (639,479), then outside.
        pixel(10'd638, 10'd479);
        chk("edge_in_draw", 32'(draw_text), 32'd1);
        chk("edge_in_offset", 32'(text_offset), 32'd0);
        chk("edge_in_glyph", 32'(font_addr[3:0]), 32'hF);
        pixel(10'd639, 10'd0);
        chk("x640_draw", 32'(draw_text), 32'd0);
        pixel(10'd700, 10'd480);
        chk("y480_draw", 32'(draw_text), 32'd0);
        pixel(10'd1023, 10'd0);
        chk("x1024_nowrap_draw", 32'(draw_text), 32'd0);

        // Read-during-write of cell 0: old data first, new data next read.
        DrawX = 10'd0; DrawY = 10'd0;
        write_cell(12'd0, 8'h42);
        chk("rdw_old", 32'(font_addr), 32'h410);
        pixel(10'd0, 10'd0);
        chk("rdw_new", 32'(font_addr), 32'h420);

        // Out-of-range write is ignored and must not alias onto cell 0.
        write_cell(12'd2400, 8'h33);
        write_cell(12'd4095, 8'h33);
        pixel(10'd0, 10'd0);
        chk("oor_ignored", 32'(font_addr), 32'h420);

        // Clear sweep with a write attempted at cycle 100.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            if (cnt == 100) begin
                wr_en = 1'b1; wr_addr = 12'd5; wr_data = 8'h41;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        chk("clear_busy_cycles", 32'(cnt), 32'd2400);
        pixel(10'd0, 10'd0);
        chk("clr_cell0", 32'(font_addr[10:4]), 32'h20);
        pixel(10'd40, 10'd0);
        chk("clr_cell5", 32'(font_addr[10:4]), 32'h20);
        pixel(10'd638, 10'd479);
        chk("clr_cell2399", 32'(font_addr[10:4]), 32'h20);
        pixel(10'd8, 10'd16);
        chk("clr_cell81", 32'(font_addr[10:4]), 32'h20);

        // Reset at cycle 500 of a sweep aborts it; a restarted sweep is full length.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        Reset = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        Reset = 1'b0;
        tick();
        chk("abort_stays_idle", 32'(busy), 32'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            tick();
        end
        chk("restart_busy_cycles", 32'(cnt), 32'd2400);

`ifdef TEXT_BLINK_EN
        write_cell(12'd0, 8'hC1);
        write_cell(12'd1, 8'h41);
        pixel(10'd0, 10'd0);
        chk("blink_pre", 32'(draw_text), 32'd1);
        for (int i = 0; i < 16; i++) begin
            frame_clk = 1'b1; tick(); tick();
            frame_clk = 1'b0; tick(); tick();
        end
        tick(); tick();
        pixel(10'd0, 10'd0);
        chk("blink_off_16", 32'(draw_text), 32'd0);
        pixel(10'd8, 10'd0);
        chk("noblink_cell_16", 32'(draw_text), 32'd1);
        for (int i = 0; i < 16; i++) begin
            frame_clk = 1'b1; tick(); tick();
            frame_clk = 1'b0; tick(); tick();
        end
        tick(); tick();
        pixel(10'd0, 10'd0);
        chk("blink_on_32", 32'(draw_text), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
